e203_itcm_arbctrl: RTL and testbench



---
 rtl/e203_itcm_arbctrl_pkg.sv | 24 ++
 rtl/e203_itcm_rspbuf.sv | 52 +++++
 rtl/e203_itcm_arbctrl.sv | 126 ++++++++++++
 tb/tb_e203_itcm_arbctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_itcm_arbctrl_pkg.sv
// ITCM arbiter shared definitions: default geometry, FSM encoding and
// the round-robin pick helper used by the top-level arbiter.
package e203_itcm_arbctrl_pkg;

    localparam int ITCM_AW          = 16;
    localparam int ITCM_DW          = 64;
    localparam int ITCM_MW          = ITCM_DW / 8;
    localparam int ITCM_ARB_LS_IDLE = 8;

    typedef enum logic [1:0] {
        ARB_RUN   = 2'd0,
        ARB_SLEEP = 2'd1,
        ARB_WAKE  = 2'd2
    } arb_state_e;

    // LSU wins when it is the only requester, or on a tie when IFU
    // was the last one granted.
    function automatic logic rr_pick_lsu(input logic ifu_req,
                                         input logic lsu_req,
                                         input logic last_lsu);
        return lsu_req && (!ifu_req || !last_lsu);
    endfunction

endpackage

// File: rtl/e203_itcm_rspbuf.sv
// Per-requester response path: pend flag, 1-entry holding buffer, eligibility.
// Ports: grant/ram_dout in, rsp_valid/rsp_ready/rsp_rdata handshake, elig out.
module e203_itcm_rspbuf
    import e203_itcm_arbctrl_pkg::*;
#(
    parameter int DW = ITCM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant,
    input  logic [DW-1:0] ram_dout,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          elig
);

    logic          pend_q, pend_d;
    logic          buf_vld_q, buf_vld_d;
    logic [DW-1:0] buf_q, buf_d;

    always_comb begin
        rsp_valid = !rst && (pend_q || buf_vld_q);
        rsp_rdata = buf_vld_q ? buf_q : ram_dout;
        // A new grant is allowed only if the previous read data leaves
        // this cycle, so the single buffer can never overflow.
        elig      = !buf_vld_q && (!pend_q || rsp_ready);
        pend_d    = grant;
        buf_vld_d = buf_vld_q;
        buf_d     = buf_q;
        if (rsp_valid && rsp_ready) begin
            buf_vld_d = 1'b0;
        end
        if (pend_q && !rsp_ready) begin
            buf_vld_d = 1'b1;
            buf_d     = ram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            buf_vld_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            buf_vld_q <= buf_vld_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: rtl/e203_itcm_arbctrl.sv
// ITCM RAM sequencer: round-robin IFU/LSU arbitration, response buffering,
// idle-driven light sleep. Ports: ifu_* / lsu_* cmd+rsp, ram_* macro pins.
module e203_itcm_arbctrl
    import e203_itcm_arbctrl_pkg::*;
#(
    parameter int AW      = ITCM_AW,
    parameter int DW      = ITCM_DW,
    parameter int MW      = ITCM_MW,
    parameter int LS_IDLE = ITCM_ARB_LS_IDLE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_cmd_valid,
    output logic          ifu_cmd_ready,
    input  logic [AW-1:0] ifu_cmd_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,
    input  logic          lsu_cmd_valid,
    output logic          lsu_cmd_ready,
    input  logic          lsu_cmd_read,
    input  logic [AW-1:0] lsu_cmd_addr,
    input  logic [DW-1:0] lsu_cmd_wdata,
    input  logic [MW-1:0] lsu_cmd_wmask,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    localparam int            CW       = $clog2(LS_IDLE + 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(LS_IDLE);

    arb_state_e    state_q, state_d;
    logic          last_lsu_q, last_lsu_d;
    logic [CW-1:0] idle_q, idle_d;

    logic run, ifu_req, lsu_req, ifu_gnt, lsu_gnt;
    logic ifu_elig, lsu_elig, any_valid, busy;

    e203_itcm_rspbuf #(.DW(DW)) u_ifu_rsp (
        .clk       (clk),
        .rst       (rst),
        .grant     (ifu_gnt),
        .ram_dout  (ram_dout),
        .rsp_ready (ifu_rsp_ready),
        .rsp_valid (ifu_rsp_valid),
        .rsp_rdata (ifu_rsp_rdata),
        .elig      (ifu_elig)
    );

    e203_itcm_rspbuf #(.DW(DW)) u_lsu_rsp (
        .clk       (clk),
        .rst       (rst),
        .grant     (lsu_gnt),
        .ram_dout  (ram_dout),
        .rsp_ready (lsu_rsp_ready),
        .rsp_valid (lsu_rsp_valid),
        .rsp_rdata (lsu_rsp_rdata),
        .elig      (lsu_elig)
    );

    assign ram_ds = 1'b0;
    assign ram_sd = 1'b0;

    always_comb begin
        run           = !rst && (state_q == ARB_RUN);
        ifu_req       = run && ifu_cmd_valid && ifu_elig;
        lsu_req       = run && lsu_cmd_valid && lsu_elig;
        lsu_gnt       = rr_pick_lsu(ifu_req, lsu_req, last_lsu_q);
        ifu_gnt       = ifu_req && !lsu_gnt;
        ifu_cmd_ready = ifu_gnt;
        lsu_cmd_ready = lsu_gnt;
        ram_cs        = ifu_gnt || lsu_gnt;
        ram_we        = lsu_gnt && !lsu_cmd_read;
        ram_addr      = lsu_gnt ? lsu_cmd_addr : ifu_cmd_addr;
        ram_din       = lsu_cmd_wdata;
        ram_wem       = lsu_gnt ? lsu_cmd_wmask : '0;
        ram_ls        = !rst && (state_q == ARB_SLEEP);

        last_lsu_d = last_lsu_q;
        if (ram_cs) begin
            last_lsu_d = lsu_gnt;
        end

        any_valid = ifu_cmd_valid || lsu_cmd_valid;
        busy      = ram_cs || ifu_rsp_valid || lsu_rsp_valid || any_valid;
        if (busy) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            ARB_RUN:   if (idle_q == IDLE_MAX && !any_valid) state_d = ARB_SLEEP;
            ARB_SLEEP: if (any_valid) state_d = ARB_WAKE;
            ARB_WAKE:  state_d = ARB_RUN;
            default:   state_d = ARB_RUN;
        endcase
    end

    // Pointer resets to "LSU last" so IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_RUN;
            last_lsu_q <= 1'b1;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: tb/tb_e203_itcm_arbctrl.sv
// Self-checking bench for e203_itcm_arbctrl: RAM model, cycle reference
// model with per-requester response queues, directed and random stimulus.
module tb_e203_itcm_arbctrl;

    localparam int AW = 16, DW = 64, MW = 8, LS_IDLE = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0] ifu_cmd_addr;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
    logic [AW-1:0] lsu_cmd_addr;
    logic [DW-1:0] lsu_cmd_wdata;
    logic [MW-1:0] lsu_cmd_wmask;
    logic          lsu_rsp_valid, lsu_rsp_ready;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [MW-1:0] ram_wem;

    always #5 clk = ~clk;

    e203_itcm_arbctrl #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS_IDLE)) dut (
        .clk(clk), .rst(rst),
        .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready),
        .ifu_cmd_addr(ifu_cmd_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready),
        .lsu_cmd_read(lsu_cmd_read), .lsu_cmd_addr(lsu_cmd_addr),
        .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_wem(ram_wem), .ram_dout(ram_dout),
        .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
    );

    int n_total = 0;
    int n_bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] init_val(int i);
        if (i == 16) return 64'h0000_0000_DEAD_BEEF;
        if (i == 4)  return 64'hAAAA_AAAA_BBBB_BBBB;
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    endfunction

    // RAM macro model, reloaded while reset is high.
    logic [63:0] ram_mem [64];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= init_val(i);
        end else if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_wem[b]) ram_mem[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram_mem[ram_addr[5:0]];
            end
        end
    end

    // Reference model state
    logic [63:0] ref_mem [64];
    bit   [1:0]  m_fresh, m_held, v, rr, q, g, e_v;
    logic [64:0] q0[$], q1[$];
    bit          m_last_lsu, any_v, busy;
    int          m_idle, m_mode;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        m_fresh    = '0;
        m_held     = '0;
        q0.delete();
        q1.delete();
        m_last_lsu = 1'b1;
        m_idle     = 0;
        m_mode     = 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ifu_cmd_ready", ifu_cmd_ready, 0);
                chk("rst_lsu_cmd_ready", lsu_cmd_ready, 0);
                chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
                chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
                chk("rst_ram_cs", ram_cs, 0);
                chk("rst_ram_we", ram_we, 0);
                chk("rst_ram_ls", ram_ls, 0);
                model_reset();
            end else begin
                v  = {lsu_cmd_valid, ifu_cmd_valid};
                rr = {lsu_rsp_ready, ifu_rsp_ready};
                for (int i = 0; i < 2; i++)
                    q[i] = (m_mode == 0) && v[i] && !m_held[i] && (!m_fresh[i] || rr[i]);
                if (q == 2'b11) g = m_last_lsu ? 2'b01 : 2'b10;
                else g = q;
                e_v = m_fresh | m_held;

                chk("ifu_cmd_ready", ifu_cmd_ready, g[0]);
                chk("lsu_cmd_ready", lsu_cmd_ready, g[1]);
                chk("ram_cs", ram_cs, g[0] | g[1]);
                chk("ram_we", ram_we, g[1] && !lsu_cmd_read);
                chk("ram_ls", ram_ls, m_mode == 1);
                chk("ram_ds_sd", {ram_ds, ram_sd}, 0);
                if (g[0]) chk("ram_addr_ifu", ram_addr, ifu_cmd_addr);
                if (g[1]) chk("ram_addr_lsu", ram_addr, lsu_cmd_addr);
                if (g[0]) chk("ram_wem_ifu", ram_wem, 0);
                if (g[1]) chk("ram_wem_lsu", ram_wem, lsu_cmd_wmask);
                if (g[1] && !lsu_cmd_read) chk("ram_din", ram_din, lsu_cmd_wdata);
                chk("ifu_rsp_valid", ifu_rsp_valid, e_v[0]);
                chk("lsu_rsp_valid", lsu_rsp_valid, e_v[1]);
                if (e_v[0] && q0.size() > 0 && q0[0][64])
                    chk("ifu_rsp_rdata", ifu_rsp_rdata, q0[0][63:0]);
                if (e_v[1] && q1.size() > 0 && q1[0][64])
                    chk("lsu_rsp_rdata", lsu_rsp_rdata, q1[0][63:0]);

                // advance the model by one clock
                if (e_v[0] && rr[0] && q0.size() > 0) void'(q0.pop_front());
                if (e_v[1] && rr[1] && q1.size() > 0) void'(q1.pop_front());
                if (g[0]) q0.push_back({1'b1, ref_mem[ifu_cmd_addr[5:0]]});
                if (g[1]) begin
                    if (lsu_cmd_read) begin
                        q1.push_back({1'b1, ref_mem[lsu_cmd_addr[5:0]]});
                    end else begin
                        q1.push_back({1'b0, 64'h0});
                        for (int b = 0; b < 8; b++)
                            if (lsu_cmd_wmask[b])
                                ref_mem[lsu_cmd_addr[5:0]][8*b +: 8] = lsu_cmd_wdata[8*b +: 8];
                    end
                end
                any_v   = v[0] | v[1];
                busy    = (g != 0) || (e_v != 0) || any_v;
                m_held  = e_v & ~rr;
                m_fresh = g;
                if (g != 0) m_last_lsu = g[1];
                case (m_mode)
                    0: if (m_idle == LS_IDLE && !any_v) m_mode = 1;
                    1: if (any_v) m_mode = 2;
                    default: m_mode = 0;
                endcase
                m_idle = busy ? 0 : ((m_idle + 1 > LS_IDLE) ? LS_IDLE : m_idle + 1);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    bit ia, la, prev_ifu, got, quiet;

    initial begin
        rst = 1'b1;
        ifu_cmd_valid = 0; ifu_cmd_addr = '0; ifu_rsp_ready = 1;
        lsu_cmd_valid = 0; lsu_cmd_read = 1; lsu_cmd_addr = '0;
        lsu_cmd_wdata = '0; lsu_cmd_wmask = '0; lsu_rsp_ready = 1;
        repeat (3) nxt();
        rst = 1'b0;
        smp();
        chk("init_ram_cs", ram_cs, 0);
        chk("init_ram_ls", ram_ls, 0);
        chk("init_ifu_rsp_valid", ifu_rsp_valid, 0);

        // IFU read of 0x10
        nxt();
        ifu_cmd_valid = 1; ifu_cmd_addr = 16'h10;
        smp();
        chk("d_ifu_gnt", ifu_cmd_ready, 1);
        chk("d_ifu_cs", ram_cs, 1);
        chk("d_ifu_addr", ram_addr, 16'h10);
        nxt();
        ifu_cmd_valid = 0;
        smp();
        chk("d_ifu_rvld", ifu_rsp_valid, 1);
        chk("d_ifu_rdata", ifu_rsp_rdata, 64'hDEAD_BEEF);

        // LSU masked write then read of addr 4
        nxt();
        lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_addr = 4;
        lsu_cmd_wdata = 64'h1122_3344_5566_7788; lsu_cmd_wmask = 8'h0F;
        smp();
        chk("d_wr_gnt", lsu_cmd_ready, 1);
        chk("d_wr_we", ram_we, 1);
        chk("d_wr_wem", ram_wem, 8'h0F);
        nxt();
        lsu_cmd_read = 1;
        smp();
        chk("d_rd_gnt", lsu_cmd_ready, 1);
        chk("d_wr_rsp", lsu_rsp_valid, 1);
        nxt();
        lsu_cmd_valid = 0;
        smp();
        chk("d_rd_rsp", lsu_rsp_valid, 1);
        chk("d_rd_data", lsu_rsp_rdata, 64'hAAAA_AAAA_5566_7788);

        // both requesters every cycle: strict alternation
        nxt();
        ifu_cmd_valid = 1; ifu_cmd_addr = 1;
        lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 2;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("alt_cs", ram_cs, 1);
            chk("alt_one", ifu_cmd_ready ^ lsu_cmd_ready, 1);
            if (k > 0) chk("alt_flip", ifu_cmd_ready, !prev_ifu);
            prev_ifu = ifu_cmd_ready;
            ia = ifu_cmd_ready;
            la = lsu_cmd_ready;
            nxt();
            if (ia) ifu_cmd_addr = 16'($urandom_range(0, 63));
            if (la) lsu_cmd_addr = 16'($urandom_range(0, 63));
        end
        ifu_cmd_valid = 0; lsu_cmd_valid = 0;
        repeat (3) nxt();

        // IFU response stalled; LSU keeps full bandwidth
        ifu_cmd_valid = 1; ifu_cmd_addr = 16'h10; ifu_rsp_ready = 0;
        smp();
        chk("st_ifu_gnt", ifu_cmd_ready, 1);
        nxt();
        ifu_cmd_addr = 16'h11;
        lsu_cmd_valid = 1; lsu_cmd_addr = 5;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("st_rvld", ifu_rsp_valid, 1);
            chk("st_rdata", ifu_rsp_rdata, 64'hDEAD_BEEF);
            chk("st_ifu_blk", ifu_cmd_ready, 0);
            chk("st_lsu_gnt", lsu_cmd_ready, 1);
            nxt();
            lsu_cmd_addr = 16'(6 + k);
        end
        ifu_rsp_ready = 1;
        smp();
        chk("st_rel_data", ifu_rsp_rdata, 64'hDEAD_BEEF);
        chk("st_rel_vld", ifu_rsp_valid, 1);
        nxt();
        lsu_cmd_valid = 0;
        smp();
        chk("st_ifu_resume", ifu_cmd_ready, 1);
        nxt();
        ifu_cmd_valid = 0;

        // idle into light sleep, then wake on IFU
        repeat (14) nxt();
        smp();
        chk("ls_on", ram_ls, 1);
        nxt();
        ifu_cmd_valid = 1; ifu_cmd_addr = 3;
        smp();
        chk("ls_v0_ls", ram_ls, 1);
        chk("ls_v0_rdy", ifu_cmd_ready, 0);
        nxt();
        smp();
        chk("ls_v1_ls", ram_ls, 0);
        chk("ls_v1_rdy", ifu_cmd_ready, 0);
        nxt();
        smp();
        chk("ls_v2_rdy", ifu_cmd_ready, 1);
        nxt();
        ifu_cmd_valid = 0;

        // random traffic with quiet windows long enough to sleep
        for (int c = 0; c < 3000; c++) begin
            smp();
            ia = ifu_cmd_valid && ifu_cmd_ready;
            la = lsu_cmd_valid && lsu_cmd_ready;
            nxt();
            quiet = (c % 400) >= 370;
            if (!ifu_cmd_valid || ia) begin
                ifu_cmd_valid = !quiet && ($urandom_range(0, 99) < 55);
                ifu_cmd_addr  = 16'($urandom_range(0, 63));
            end
            if (!lsu_cmd_valid || la) begin
                lsu_cmd_valid = !quiet && ($urandom_range(0, 99) < 55);
                lsu_cmd_read  = $urandom_range(0, 1) == 1;
                lsu_cmd_addr  = 16'($urandom_range(0, 63));
                lsu_cmd_wdata = {$urandom, $urandom};
                lsu_cmd_wmask = 8'($urandom_range(0, 255));
            end
            ifu_rsp_ready = quiet || ($urandom_range(0, 99) < 70);
            lsu_rsp_ready = quiet || ($urandom_range(0, 99) < 70);
        end

        // reset right after an accepted LSU read
        ifu_cmd_valid = 0; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 7;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            smp();
            if (lsu_cmd_ready) got = 1;
            else nxt();
        end
        chk("mr_accept", got, 1);
        nxt();
        lsu_cmd_valid = 0;
        rst = 1;
        smp();
        chk("mr_rvld_in_rst", lsu_rsp_valid, 0);
        nxt();
        rst = 0;
        smp();
        chk("mr_rvld_after", lsu_rsp_valid, 0);
        chk("mr_ifu_rvld", ifu_rsp_valid, 0);
        chk("mr_cs", ram_cs, 0);
        chk("mr_we", ram_we, 0);
        chk("mr_ls", ram_ls, 0);
        chk("mr_rdy", {ifu_cmd_ready, lsu_cmd_ready}, 0);
        nxt();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
